// File: rtl/ahb_cache_bridge_pkg.sv
// Shared encodings for the AHB cache bridge: HTRANS/HSIZE codes, FSM states,
// and the latched transfer attributes.
package ahb_cache_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    typedef struct packed {
        logic       wr;
        logic [3:0] mask;
    } xfer_t;

endpackage

// File: rtl/ahb_cache_bridge_if.sv
// AHB5-Lite subordinate port between the Hazard3 bus and the cache bridge.
interface ahb_cache_bridge_if #(parameter int ADDR_WIDTH = 32);
    logic                  ahbls_hsel;
    logic [ADDR_WIDTH-1:0] ahbls_haddr;
    logic                  ahbls_hwrite;
    logic [1:0]            ahbls_htrans;
    logic [2:0]            ahbls_hsize;
    logic                  ahbls_hready;
    logic [31:0]           ahbls_hwdata;
    logic                  ahbls_hreadyout;
    logic                  ahbls_hresp;
    logic [31:0]           ahbls_hrdata;

    modport master (
        output ahbls_hsel, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
               ahbls_hsize, ahbls_hready, ahbls_hwdata,
        input  ahbls_hreadyout, ahbls_hresp, ahbls_hrdata
    );

    modport slave (
        input  ahbls_hsel, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
               ahbls_hsize, ahbls_hready, ahbls_hwdata,
        output ahbls_hreadyout, ahbls_hresp, ahbls_hrdata
    );
endinterface

// File: rtl/ahb_cache_bridge_byte_mask.sv
// Byte-lane enables and alignment flag for an AHB transfer; shared with the
// uncached-peripheral bridge.
module ahb_byte_mask
    import ahb_cache_bridge_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       misaligned
);

    // Oversized transfers fall through to a full-word mask.
    always_comb begin
        mask       = 4'hf;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                mask       = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            default:    misaligned = |addr_lo;
        endcase
    end

endmodule

// File: rtl/ahb_cache_bridge.sv
// AHB5-Lite subordinate turning bus transfers into single-cycle cache rd/wr pulses.
// Define AHB_CACHE_BRIDGE_ERR_EN to answer misaligned/oversized/out-of-region transfers with ERROR.
module ahb_cache_bridge
    import ahb_cache_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_MASK  = 32'hff00_0000,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_x,
    ahb_cache_bridge_if.slave     ahb,
    output logic                  o_rd_en,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_data,
    output logic [3:0]            o_mask,
    input  logic [31:0]           i_data,
    input  logic                  i_busy
);

    state_t                state;
    xfer_t                 xfer_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           rdata_q;
    logic [3:0]            mask_c;
    logic                  misaligned;
    logic                  xfer_bad;
    logic                  capture;
    logic                  cap_err;
    logic                  done;
    logic                  hready_o;
    logic                  unused_chk;

    ahb_byte_mask u_mask (
        .hsize      (ahb.ahbls_hsize),
        .addr_lo    (ahb.ahbls_haddr[1:0]),
        .mask       (mask_c),
        .misaligned (misaligned)
    );

    assign capture  = ahb.ahbls_hsel && ahb.ahbls_hready && ahb.ahbls_htrans[1];
    assign xfer_bad = misaligned || (ahb.ahbls_hsize > HSIZE_WORD)
                   || ((ahb.ahbls_haddr & BASE_MASK) != BASE_ADDR);
    assign done     = (state == ST_WAIT) && !i_busy;

`ifdef AHB_CACHE_BRIDGE_ERR_EN
    assign cap_err         = xfer_bad;
    assign ahb.ahbls_hresp = (state == ST_ERR1) || (state == ST_ERR2);
`else
    assign cap_err         = 1'b0;
    assign ahb.ahbls_hresp = 1'b0;
`endif

    assign unused_chk = ^{ahb.ahbls_htrans[0], xfer_bad};

    // Any cycle that completes a data phase may also accept the next address phase.
    assign hready_o = !((state == ST_REQ) || (state == ST_ERR1) || ((state == ST_WAIT) && i_busy));

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state   <= ST_IDLE;
            xfer_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (done && !xfer_q.wr)
                rdata_q <= i_data;
            if (hready_o) begin
                if (capture && !cap_err) begin
                    state       <= ST_REQ;
                    addr_q      <= {ahb.ahbls_haddr[ADDR_WIDTH-1:2], 2'b00};
                    xfer_q.wr   <= ahb.ahbls_hwrite;
                    xfer_q.mask <= mask_c;
                end else if (capture) begin
                    state <= ST_ERR1;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (state == ST_REQ && !i_busy) begin
                state <= ST_WAIT;
            end else if (state == ST_ERR1) begin
                state <= ST_ERR2;
            end
        end
    end

    // Request pulses are gated by i_busy so the cache never sees one while refilling.
    assign o_rd_en = (state == ST_REQ) && !i_busy && !xfer_q.wr;
    assign o_wr_en = (state == ST_REQ) && !i_busy &&  xfer_q.wr;
    assign o_addr  = addr_q;
    assign o_mask  = xfer_q.mask;
    assign o_data  = ((state == ST_REQ) && xfer_q.wr) ? ahb.ahbls_hwdata : '0;

    assign ahb.ahbls_hreadyout = hready_o;
    assign ahb.ahbls_hrdata    = (done && !xfer_q.wr) ? i_data : rdata_q;

endmodule

// File: tb/tb_ahb_cache_bridge.sv
// Scoreboarded bench for ahb_cache_bridge: expected requests/read data queued at drive time.
module tb_ahb_cache_bridge;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] last_rd = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        o_rd_en, o_wr_en;
    logic [31:0] o_addr, o_data;
    logic [3:0]  o_mask;
    logic [31:0] i_data;
    logic        i_busy;

    ahb_cache_bridge_if #(.ADDR_WIDTH(32)) ahb ();
    assign ahb.ahbls_hready = ahb.ahbls_hreadyout;

    ahb_cache_bridge dut (
        .clk     (clk),
        .rst_x   (rst_x),
        .ahb     (ahb.slave),
        .o_rd_en (o_rd_en),
        .o_wr_en (o_wr_en),
        .o_addr  (o_addr),
        .o_data  (o_data),
        .o_mask  (o_mask),
        .i_data  (i_data),
        .i_busy  (i_busy)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        ahb.ahbls_hsel   = 1'b0;
        ahb.ahbls_htrans = 2'd0;
        ahb.ahbls_haddr  = 32'h0;
        ahb.ahbls_hwrite = 1'b0;
        ahb.ahbls_hsize  = 3'd0;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        ahb.ahbls_hsel   = 1'b1;
        ahb.ahbls_htrans = 2'd2;
        ahb.ahbls_haddr  = a;
        ahb.ahbls_hwrite = wr;
        ahb.ahbls_hsize  = sz;
    endtask

    // Runs one data phase from its first cycle until hreadyout, driving i_busy
    // high for busy_pre cycles before the pulse and busy_post cycles after it.
    task automatic data_phase(input int busy_pre, input int busy_post,
                              output int cyc, output int pulses, output int viol,
                              output req_t seen, output logic [31:0] rd, output logic resp);
        int  post = 0;
        bit  fin = 0;
        cyc = 0; pulses = 0; viol = 0; seen = '0; rd = '0; resp = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            i_busy = (cyc < busy_pre) || (pulses > 0 && post < busy_post);
            @(negedge clk);
            cyc++;
            if (o_rd_en || o_wr_en) begin
                pulses++;
                if ((o_rd_en && o_wr_en) || i_busy) viol++;
                seen = '{wr: o_wr_en, addr: o_addr, mask: o_mask, data: o_data};
            end else if (pulses > 0) begin
                post++;
            end
            if (ahb.ahbls_hreadyout) begin
                rd   = ahb.ahbls_hrdata;
                resp = ahb.ahbls_hresp;
                fin  = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [103:0] got;
        repeat (2) @(posedge clk);
        #1;
        got = {ahb.ahbls_hreadyout, ahb.ahbls_hresp, ahb.ahbls_hrdata, o_rd_en, o_wr_en, o_addr, o_data, o_mask};
        n_cmp++; if (got !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", got, {1'b1, 1'b0, 102'h0}); end
        rst_x = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ahb.ahbls_hreadyout, ahb.ahbls_hresp} !== 2'b10) begin
            n_bad++; $display("FAIL reset_release_okay: got %b want 10", {ahb.ahbls_hreadyout, ahb.ahbls_hresp}); end
    endtask

    task automatic test_read_hit();
        req_t e, s; int cyc, np, viol; logic [31:0] rd, er; logic resp;
        @(posedge clk); #1;
        i_data = 32'hdeadbeef; i_busy = 1'b0;
        addr_phase(1'b0, 32'h119f0, 3'd2);
        exp_q.push_back('{wr: 1'b0, addr: 32'h119f0, mask: 4'hf, data: 32'h0});
        exp_rd_q.push_back(32'hdeadbeef);
        @(posedge clk); #1;
        bus_idle();
        data_phase(0, 0, cyc, np, viol, s, rd, resp);
        e = exp_q.pop_front(); er = exp_rd_q.pop_front(); last_rd = er;
        n_cmp++; if ({s.wr, s.addr, s.mask} !== {e.wr, e.addr, e.mask}) begin
            n_bad++; $display("FAIL rd_hit_req: got %h want %h", {s.wr, s.addr, s.mask}, {e.wr, e.addr, e.mask}); end
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL rd_hit_latency: got %0d want 2", cyc); end
        n_cmp++; if (np !== 1 || viol !== 0) begin n_bad++; $display("FAIL rd_hit_pulses: got %0d/%0d want 1/0", np, viol); end
        n_cmp++; if (rd !== er || resp !== 1'b0) begin n_bad++; $display("FAIL rd_hit_data: got %h/%b want %h/0", rd, resp, er); end
        @(posedge clk); #1;
        i_data = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (ahb.ahbls_hrdata !== last_rd) begin
            n_bad++; $display("FAIL rd_hold: got %h want %h", ahb.ahbls_hrdata, last_rd); end
    endtask

    task automatic test_byte_write();
        req_t e, s; int cyc, np, viol; logic [31:0] rd; logic resp;
        @(posedge clk); #1;
        i_data = 32'h55555555;
        addr_phase(1'b1, 32'h1003, 3'd0);
        exp_q.push_back('{wr: 1'b1, addr: 32'h1000, mask: 4'b1000, data: 32'haaaaaaaa});
        @(posedge clk); #1;
        bus_idle();
        ahb.ahbls_hwdata = 32'haaaaaaaa;
        data_phase(0, 5, cyc, np, viol, s, rd, resp);
        e = exp_q.pop_front();
        n_cmp++; if (s !== e) begin n_bad++; $display("FAIL wr_byte_req: got %h want %h", s, e); end
        n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL wr_byte_stall: got %0d want 7 (6 low + done)", cyc); end
        n_cmp++; if (np !== 1 || viol !== 0) begin n_bad++; $display("FAIL wr_byte_pulses: got %0d/%0d want 1/0", np, viol); end
        n_cmp++; if (rd !== last_rd || resp !== 1'b0) begin
            n_bad++; $display("FAIL wr_byte_hrdata_hold: got %h/%b want %h/0", rd, resp, last_rd); end
    endtask

    task automatic test_masks();
        logic [31:0] ta [4] = '{32'h2001, 32'h2002, 32'h2000, 32'h2003};
        logic [2:0]  ts [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
        logic [3:0]  tm [4] = '{4'b0010, 4'b1100, 4'b0011, 4'b1000};
        req_t e, s; int cyc, np, viol; logic [31:0] rd, er; logic resp;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            i_data = 32'hc0de0000 + i;
            addr_phase(1'b0, ta[i], ts[i]);
            exp_q.push_back('{wr: 1'b0, addr: ta[i] & ~32'h3, mask: tm[i], data: 32'h0});
            exp_rd_q.push_back(32'hc0de0000 + i);
            @(posedge clk); #1;
            bus_idle();
            data_phase(0, 0, cyc, np, viol, s, rd, resp);
            e = exp_q.pop_front(); er = exp_rd_q.pop_front(); last_rd = er;
            n_cmp++; if ({s.wr, s.addr, s.mask} !== {e.wr, e.addr, e.mask} || cyc !== 2) begin
                n_bad++; $display("FAIL mask_%0d: got %h cyc %0d want %h cyc 2", i, {s.wr, s.addr, s.mask}, cyc, {e.wr, e.addr, e.mask}); end
            n_cmp++; if (rd !== er) begin n_bad++; $display("FAIL mask_%0d_data: got %h want %h", i, rd, er); end
        end
    endtask

    task automatic test_busy_refill();
        req_t e, s; int cyc, np, viol; logic [31:0] rd, er; logic resp;
        @(posedge clk); #1;
        i_data = 32'h0f0f0f0f;
        addr_phase(1'b0, 32'h3004, 3'd2);
        exp_q.push_back('{wr: 1'b0, addr: 32'h3004, mask: 4'hf, data: 32'h0});
        exp_rd_q.push_back(32'h0f0f0f0f);
        @(posedge clk); #1;
        bus_idle();
        data_phase(3, 0, cyc, np, viol, s, rd, resp);
        e = exp_q.pop_front(); er = exp_rd_q.pop_front(); last_rd = er;
        n_cmp++; if ({s.wr, s.addr, s.mask} !== {e.wr, e.addr, e.mask}) begin
            n_bad++; $display("FAIL refill_req: got %h want %h", {s.wr, s.addr, s.mask}, {e.wr, e.addr, e.mask}); end
        n_cmp++; if (np !== 1 || viol !== 0 || cyc !== 5) begin
            n_bad++; $display("FAIL refill_pulse: got pulses %0d viol %0d cyc %0d want 1 0 5", np, viol, cyc); end
        n_cmp++; if (rd !== er) begin n_bad++; $display("FAIL refill_data: got %h want %h", rd, er); end
    endtask

    task automatic test_back_to_back();
        req_t e, s; int cyc, np, viol; logic [31:0] rd, er; logic resp;
        @(posedge clk); #1;
        i_data = 32'h0badf00d;
        addr_phase(1'b0, 32'h100, 3'd2);
        exp_q.push_back('{wr: 1'b0, addr: 32'h100, mask: 4'hf, data: 32'h0});
        exp_rd_q.push_back(32'h0badf00d);
        @(posedge clk); #1;
        addr_phase(1'b1, 32'h104, 3'd2);
        ahb.ahbls_hwdata = 32'h11111111;
        exp_q.push_back('{wr: 1'b1, addr: 32'h104, mask: 4'hf, data: 32'hcafef00d});
        data_phase(0, 2, cyc, np, viol, s, rd, resp);
        e = exp_q.pop_front(); er = exp_rd_q.pop_front(); last_rd = er;
        n_cmp++; if ({s.wr, s.addr, s.mask} !== {e.wr, e.addr, e.mask} || np !== 1 || cyc !== 4) begin
            n_bad++; $display("FAIL b2b_first: got %h pulses %0d cyc %0d want %h 1 4", {s.wr, s.addr, s.mask}, np, cyc, {e.wr, e.addr, e.mask}); end
        n_cmp++; if (rd !== er) begin n_bad++; $display("FAIL b2b_rdata: got %h want %h", rd, er); end
        @(posedge clk); #1;
        bus_idle();
        ahb.ahbls_hwdata = 32'hcafef00d;
        data_phase(0, 0, cyc, np, viol, s, rd, resp);
        e = exp_q.pop_front();
        n_cmp++; if (s !== e || np !== 1 || viol !== 0 || cyc !== 2) begin
            n_bad++; $display("FAIL b2b_second: got %h pulses %0d cyc %0d want %h 1 2", s, np, cyc, e); end
    endtask

    task automatic test_misaligned();
`ifdef AHB_CACHE_BRIDGE_ERR_EN
        logic [1:0] exp_rr [3] = '{2'b01, 2'b11, 2'b10};
        int np = 0;
        @(posedge clk); #1;
        i_busy = 1'b0;
        addr_phase(1'b0, 32'h102, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_rd_en || o_wr_en) np++;
            n_cmp++; if ({ahb.ahbls_hreadyout, ahb.ahbls_hresp} !== exp_rr[i]) begin
                n_bad++; $display("FAIL err_cycle_%0d: got %b want %b", i, {ahb.ahbls_hreadyout, ahb.ahbls_hresp}, exp_rr[i]); end
            @(posedge clk); #1;
        end
        n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL err_no_pulse: got %0d want 0", np); end
`else
        req_t e, s; int cyc, np, viol; logic [31:0] rd, er; logic resp;
        @(posedge clk); #1;
        i_data = 32'h600dcafe;
        addr_phase(1'b0, 32'h102, 3'd2);
        exp_q.push_back('{wr: 1'b0, addr: 32'h100, mask: 4'hf, data: 32'h0});
        exp_rd_q.push_back(32'h600dcafe);
        @(posedge clk); #1;
        bus_idle();
        data_phase(0, 0, cyc, np, viol, s, rd, resp);
        e = exp_q.pop_front(); er = exp_rd_q.pop_front(); last_rd = er;
        n_cmp++; if ({s.wr, s.addr, s.mask} !== {e.wr, e.addr, e.mask} || np !== 1) begin
            n_bad++; $display("FAIL misaligned_req: got %h want %h", {s.wr, s.addr, s.mask}, {e.wr, e.addr, e.mask}); end
        n_cmp++; if (resp !== 1'b0 || cyc !== 2 || rd !== er) begin
            n_bad++; $display("FAIL misaligned_okay: got resp %b cyc %0d data %h want 0 2 %h", resp, cyc, rd, er); end
`endif
    endtask

    task automatic test_reset_wait();
        req_t e, s; int np = 0; logic [103:0] got;
        @(posedge clk); #1;
        i_busy = 1'b0;
        addr_phase(1'b0, 32'h400, 3'd2);
        exp_q.push_back('{wr: 1'b0, addr: 32'h400, mask: 4'hf, data: 32'h0});
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        s = '{wr: o_wr_en, addr: o_addr, mask: o_mask, data: 32'h0};
        e = exp_q.pop_front();
        n_cmp++; if (!o_rd_en || {s.addr, s.mask} !== {e.addr, e.mask}) begin
            n_bad++; $display("FAIL rstw_pulse: got rd %b %h want 1 %h", o_rd_en, {s.addr, s.mask}, {e.addr, e.mask}); end
        @(posedge clk); #1;
        i_busy = 1'b1;
        @(negedge clk);
        n_cmp++; if (ahb.ahbls_hreadyout !== 1'b0) begin n_bad++; $display("FAIL rstw_stalled: got %b want 0", ahb.ahbls_hreadyout); end
        #1 rst_x = 1'b0;
        #1;
        got = {ahb.ahbls_hreadyout, ahb.ahbls_hresp, ahb.ahbls_hrdata, o_rd_en, o_wr_en, o_addr, o_data, o_mask};
        n_cmp++; if (got !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
            n_bad++; $display("FAIL rstw_async: got %h want %h", got, {1'b1, 1'b0, 102'h0}); end
        @(posedge clk); #1;
        rst_x = 1'b1;
        i_busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_rd_en || o_wr_en) np++;
        end
        n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL rstw_abandoned: got %0d pulses want 0", np); end
        @(posedge clk); #1;
        ahb.ahbls_hsel = 1'b1; ahb.ahbls_htrans = 2'd0; ahb.ahbls_haddr = 32'h500;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        n_cmp++; if ({ahb.ahbls_hreadyout, ahb.ahbls_hresp, o_rd_en, o_wr_en} !== 4'b1000) begin
            n_bad++; $display("FAIL idle_zero_wait: got %b want 1000", {ahb.ahbls_hreadyout, ahb.ahbls_hresp, o_rd_en, o_wr_en}); end
    endtask

    initial begin
        i_busy = 1'b0;
        i_data = 32'h0;
        ahb.ahbls_hwdata = 32'h0;
        bus_idle();
        test_reset();
        test_read_hit();
        test_byte_write();
        test_masks();
        test_busy_refill();
        test_back_to_back();
        test_misaligned();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
